// File: rtl/soc_periph_bus_ctrl_pkg.sv
// Shared types, SoC address map and address decoder for the peripheral bus controller.
package soc_periph_bus_ctrl_pkg;

  localparam int unsigned NB_PERIPHERALS = 9;
  localparam int unsigned AddrW          = 64;
  localparam int unsigned DataW          = 64;
  localparam int unsigned BeW            = 8;

  typedef enum logic [3:0] {
    DRAM     = 4'd0,
    GPIO     = 4'd1,
    ETHERNET = 4'd2,
    SPI      = 4'd3,
    UART     = 4'd4,
    PLIC     = 4'd5,
    CLINT    = 4'd6,
    ROM      = 4'd7,
    DEBUG    = 4'd8
  } axi_slaves_t;

  localparam logic [AddrW-1:0] DebugBase    = 64'h0000_0000;
  localparam logic [AddrW-1:0] DebugLength  = 64'h0000_1000;
  localparam logic [AddrW-1:0] ROMBase      = 64'h0001_0000;
  localparam logic [AddrW-1:0] ROMLength    = 64'h0001_0000;
  localparam logic [AddrW-1:0] CLINTBase    = 64'h0200_0000;
  localparam logic [AddrW-1:0] CLINTLength  = 64'h000C_0000;
  localparam logic [AddrW-1:0] PLICBase     = 64'h0C00_0000;
  localparam logic [AddrW-1:0] PLICLength   = 64'h03FF_FFFF;
  localparam logic [AddrW-1:0] UARTBase     = 64'h1000_0000;
  localparam logic [AddrW-1:0] UARTLength   = 64'h0000_1000;
  localparam logic [AddrW-1:0] SPIBase      = 64'h2000_0000;
  localparam logic [AddrW-1:0] SPILength    = 64'h0080_0000;
  localparam logic [AddrW-1:0] EthernetBase = 64'h3000_0000;
  localparam logic [AddrW-1:0] EthernetLength = 64'h0001_0000;
  localparam logic [AddrW-1:0] GPIOBase     = 64'h4000_0000;
  localparam logic [AddrW-1:0] GPIOLength   = 64'h0000_1000;
  localparam logic [AddrW-1:0] DRAMBase     = 64'h8000_0000;
  localparam logic [AddrW-1:0] DRAMLength   = 64'h4000_0000;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic             we;
    logic [DataW-1:0] wdata;
    logic [BeW-1:0]   be;
  } periph_req_t;

  typedef struct packed {
    logic [DataW-1:0] rdata;
    logic             err;
  } periph_rsp_t;

  // Subtracting after the lower-bound test keeps the upper-bound check free of overflow.
  function automatic logic in_range(input logic [AddrW-1:0] addr,
                                    input logic [AddrW-1:0] base,
                                    input logic [AddrW-1:0] len);
    return (addr >= base) && ((addr - base) < len);
  endfunction

  function automatic logic [NB_PERIPHERALS-1:0] addr_decode(input logic [AddrW-1:0] addr);
    logic [NB_PERIPHERALS-1:0] hit;
    hit           = '0;
    hit[DRAM]     = in_range(addr, DRAMBase, DRAMLength);
    hit[GPIO]     = in_range(addr, GPIOBase, GPIOLength);
    hit[ETHERNET] = in_range(addr, EthernetBase, EthernetLength);
    hit[SPI]      = in_range(addr, SPIBase, SPILength);
    hit[UART]     = in_range(addr, UARTBase, UARTLength);
    hit[PLIC]     = in_range(addr, PLICBase, PLICLength);
    hit[CLINT]    = in_range(addr, CLINTBase, CLINTLength);
    hit[ROM]      = in_range(addr, ROMBase, ROMLength);
    hit[DEBUG]    = in_range(addr, DebugBase, DebugLength);
    // Keep only the lowest-index hit so overlapping windows stay one-hot.
    return hit & (~hit + NB_PERIPHERALS'(1));
  endfunction

endpackage

// File: rtl/soc_periph_bus_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after rr_ptr, wrapping.
module soc_periph_bus_ctrl_rr_arbiter #(
  parameter int unsigned NumMst = 2
) (
  input  logic [NumMst-1:0]                                 req,
  input  logic [((NumMst > 1) ? $clog2(NumMst) : 1)-1:0]    rr_ptr,
  output logic [NumMst-1:0]                                 gnt,
  output logic [((NumMst > 1) ? $clog2(NumMst) : 1)-1:0]    idx,
  output logic                                              valid
);

  localparam int unsigned IdxW = (NumMst > 1) ? $clog2(NumMst) : 1;

  function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NumMst) s = s - NumMst;
    return IdxW'(s);
  endfunction

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < NumMst; i++) begin
      if (!valid && req[wrap_idx(rr_ptr, i)]) begin
        valid = 1'b1;
        idx   = wrap_idx(rr_ptr, i);
      end
    end
    if (valid) gnt = NumMst'(1) << idx;
  end

endmodule

// File: rtl/soc_periph_bus_ctrl.sv
// Single-outstanding peripheral bus controller: round-robin arbitration, address decode,
// request/response sequencing with decode-error and timeout responses.
module soc_periph_bus_ctrl
  import soc_periph_bus_ctrl_pkg::*;
#(
  parameter int unsigned NumMst        = 2,
  parameter int unsigned NumSlv        = NB_PERIPHERALS,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumMst-1:0]             mst_req_i,
  input  logic [NumMst-1:0][AddrW-1:0]  mst_addr_i,
  input  logic [NumMst-1:0]             mst_we_i,
  input  logic [NumMst-1:0][DataW-1:0]  mst_wdata_i,
  input  logic [NumMst-1:0][BeW-1:0]    mst_be_i,
  output logic [NumMst-1:0]             mst_gnt_o,
  output logic [NumMst-1:0]             mst_rvalid_o,
  output logic [DataW-1:0]              mst_rdata_o,
  output logic                          mst_err_o,
  output logic                          slv_req_o,
  output logic [NumSlv-1:0]             slv_sel_o,
  output logic [AddrW-1:0]              slv_addr_o,
  output logic                          slv_we_o,
  output logic [DataW-1:0]              slv_wdata_o,
  output logic [BeW-1:0]                slv_be_o,
  input  logic                          slv_gnt_i,
  input  logic                          slv_rvalid_i,
  input  logic [DataW-1:0]              slv_rdata_i,
  input  logic                          slv_err_i
);

  localparam int unsigned IdxW = (NumMst > 1) ? $clog2(NumMst) : 1;
  localparam int unsigned CntW = $clog2(TimeoutCycles);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] DERR = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  periph_req_t         req_q, req_d;
  periph_rsp_t         rsp_q, rsp_d;
  logic [NumSlv-1:0]   sel_q, sel_d;
  logic [NumMst-1:0]   rvalid_q, rvalid_d;

  logic [NumMst-1:0]   arb_gnt;
  logic [IdxW-1:0]     arb_idx;
  logic                arb_valid;
  logic [NumSlv-1:0]   dec_sel;
  logic [NumMst-1:0]   owner_hot;
  logic                timeout;

  soc_periph_bus_ctrl_rr_arbiter #(.NumMst(NumMst)) u_arb (
    .req    (mst_req_i),
    .rr_ptr (rr_ptr_q),
    .gnt    (arb_gnt),
    .idx    (arb_idx),
    .valid  (arb_valid)
  );

  assign dec_sel   = NumSlv'(addr_decode(mst_addr_i[arb_idx]));
  assign owner_hot = NumMst'(1) << owner_q;
  assign timeout   = (cnt_q == CntW'(TimeoutCycles - 1));

  // Next-state, datapath capture and the combinational grant.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    rsp_d     = rsp_q;
    sel_d     = sel_q;
    rvalid_d  = '0;
    mst_gnt_o = '0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          mst_gnt_o   = arb_gnt;
          owner_d     = arb_idx;
          req_d.addr  = mst_addr_i[arb_idx];
          req_d.we    = mst_we_i[arb_idx];
          req_d.wdata = mst_wdata_i[arb_idx];
          req_d.be    = mst_be_i[arb_idx];
          sel_d       = dec_sel;
          rr_ptr_d    = (arb_idx == IdxW'(NumMst - 1)) ? '0 : arb_idx + IdxW'(1);
          cnt_d       = '0;
          state_d     = (|dec_sel) ? REQ : DERR;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CntW'(1);
        if (slv_gnt_i && slv_rvalid_i) begin
          rvalid_d    = owner_hot;
          rsp_d.rdata = slv_rdata_i;
          rsp_d.err   = slv_err_i;
          state_d     = IDLE;
        end else if (timeout) begin
          rvalid_d    = owner_hot;
          rsp_d.rdata = '0;
          rsp_d.err   = 1'b1;
          state_d     = IDLE;
        end else if (slv_gnt_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d = cnt_q + CntW'(1);
        if (slv_rvalid_i) begin
          rvalid_d    = owner_hot;
          rsp_d.rdata = slv_rdata_i;
          rsp_d.err   = slv_err_i;
          state_d     = IDLE;
        end else if (timeout) begin
          rvalid_d    = owner_hot;
          rsp_d.rdata = '0;
          rsp_d.err   = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        rvalid_d    = owner_hot;
        rsp_d.rdata = '0;
        rsp_d.err   = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      req_q    <= '0;
      rsp_q    <= '0;
      sel_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      rsp_q    <= rsp_d;
      sel_q    <= sel_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign slv_req_o    = (state_q == REQ);
  assign slv_sel_o    = ((state_q == REQ) || (state_q == RESP)) ? sel_q : '0;
  assign slv_addr_o   = req_q.addr;
  assign slv_we_o     = req_q.we;
  assign slv_wdata_o  = req_q.wdata;
  assign slv_be_o     = req_q.be;
  assign mst_rvalid_o = rvalid_q;
  assign mst_rdata_o  = rsp_q.rdata;
  assign mst_err_o    = rsp_q.err;

endmodule

// File: tb/tb_soc_periph_bus_ctrl.sv
// Randomized self-checking bench for soc_periph_bus_ctrl with an address-map/latency reference model.
module tb_soc_periph_bus_ctrl;
  import soc_periph_bus_ctrl_pkg::*;

  localparam int NM = 2;
  localparam int NS = NB_PERIPHERALS;
  localparam int TO = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NM-1:0]        mst_req = '0;
  logic [NM-1:0][63:0]  mst_addr = '0;
  logic [NM-1:0]        mst_we = '0;
  logic [NM-1:0][63:0]  mst_wdata = '0;
  logic [NM-1:0][7:0]   mst_be = '0;
  logic [NM-1:0]        mst_gnt, mst_rvalid;
  logic [63:0]          mst_rdata;
  logic                 mst_err;
  logic                 slv_req;
  logic [NS-1:0]        slv_sel;
  logic [63:0]          slv_addr, slv_wdata, slv_rdata = '0;
  logic                 slv_we, slv_gnt = 1'b0, slv_rvalid = 1'b0, slv_err = 1'b0;
  logic [7:0]           slv_be;

  always #5 clk = ~clk;

  soc_periph_bus_ctrl #(.NumMst(NM), .NumSlv(NS), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mst_req_i(mst_req), .mst_addr_i(mst_addr), .mst_we_i(mst_we),
    .mst_wdata_i(mst_wdata), .mst_be_i(mst_be),
    .mst_gnt_o(mst_gnt), .mst_rvalid_o(mst_rvalid), .mst_rdata_o(mst_rdata), .mst_err_o(mst_err),
    .slv_req_o(slv_req), .slv_sel_o(slv_sel), .slv_addr_o(slv_addr), .slv_we_o(slv_we),
    .slv_wdata_o(slv_wdata), .slv_be_o(slv_be),
    .slv_gnt_i(slv_gnt), .slv_rvalid_i(slv_rvalid), .slv_rdata_i(slv_rdata), .slv_err_i(slv_err)
  );

  int checks_total  = 0;
  int checks_passed = 0;
  int rr_model      = 0;

  // Slave model: grants gnt_wait cycles into a request, answers rv_wait cycles after the grant.
  int          gnt_wait = 0;
  int          rv_wait  = 1;
  logic [63:0] sl_rdata = '0;
  logic        sl_err   = 1'b0;
  int          sl_cnt   = 0;
  int          sl_rcnt  = 0;
  bit          sl_granted = 1'b0;

  always @(posedge clk) begin
    #1;
    slv_gnt = 1'b0; slv_rvalid = 1'b0; slv_rdata = '0; slv_err = 1'b0;
    if (!rst_n) begin
      sl_granted = 1'b0; sl_cnt = 0;
    end else if (!sl_granted) begin
      if (slv_req) begin
        if (sl_cnt == gnt_wait) begin
          slv_gnt = 1'b1; sl_granted = 1'b1; sl_rcnt = 0; sl_cnt = 0;
          if (rv_wait == 0) begin
            slv_rvalid = 1'b1; slv_rdata = sl_rdata; slv_err = sl_err; sl_granted = 1'b0;
          end
        end else sl_cnt++;
      end else sl_cnt = 0;
    end else begin
      sl_rcnt++;
      if (sl_rcnt == rv_wait) begin
        slv_rvalid = 1'b1; slv_rdata = sl_rdata; slv_err = sl_err; sl_granted = 1'b0;
      end
    end
  end

  // Address map as inclusive windows, independent of the RTL decoder.
  localparam logic [63:0] RLO [9] = '{64'h0, 64'h1_0000, 64'h200_0000, 64'hC00_0000, 64'h1000_0000,
                                      64'h2000_0000, 64'h3000_0000, 64'h4000_0000, 64'h8000_0000};
  localparam logic [63:0] RHI [9] = '{64'hFFF, 64'h1_FFFF, 64'h20B_FFFF, 64'hFFF_FFFE, 64'h1000_0FFF,
                                      64'h207F_FFFF, 64'h3000_FFFF, 64'h4000_0FFF, 64'hBFFF_FFFF};
  localparam int RSLV [9] = '{int'(DEBUG), int'(ROM), int'(CLINT), int'(PLIC), int'(UART),
                              int'(SPI), int'(ETHERNET), int'(GPIO), int'(DRAM)};

  function automatic int ref_decode(input logic [63:0] a);
    for (int i = 0; i < 9; i++) if (a >= RLO[i] && a <= RHI[i]) return RSLV[i];
    return -1;
  endfunction

  function automatic logic [63:0] rand_addr();
    int k;
    logic [63:0] span;
    k = $urandom_range(0, 11);
    if (k >= 9) begin
      case (k)
        9:       return 64'h5000_0000 + 64'($urandom_range(0, 4095));
        10:      return 64'hC000_0000;
        default: return {32'hFFFF_FFFF, $urandom};
      endcase
    end
    span = RHI[k] - RLO[k] + 64'd1;
    case ($urandom_range(0, 3))
      0:       return RLO[k];
      1:       return RHI[k];
      2:       return RHI[k] + 64'd1;
      default: return RLO[k] + (64'($urandom) % span);
    endcase
  endfunction

  // One single-requester transaction; expectations come from the map and the slave timing.
  task automatic run_txn(input int m, input logic [63:0] addr, input logic we,
                         input logic [63:0] wd, input logic [7:0] be,
                         input int gw, input int rw, input logic [63:0] rd, input logic er);
    int          idx, lat, waited;
    bit          got, timed_out;
    logic        exp_err;
    logic [63:0] exp_rd;
    logic [NM-1:0] exp_hot;
    gnt_wait = gw; rv_wait = rw; sl_rdata = rd; sl_err = er;
    exp_hot = NM'(1) << m;
    @(posedge clk); #1;
    mst_req[m] = 1'b1; mst_addr[m] = addr; mst_we[m] = we; mst_wdata[m] = wd; mst_be[m] = be;
    waited = 0; got = 1'b0;
    while (!got && waited < 20) begin
      @(negedge clk);
      if (mst_gnt !== '0) got = 1'b1; else waited++;
    end
    checks_total++;
    if (mst_gnt !== exp_hot) $display("FAIL txn_gnt m%0d: got %b expected %b", m, mst_gnt, exp_hot);
    else checks_passed++;
    rr_model = (m + 1) % NM;
    idx = ref_decode(addr);
    timed_out = 1'b0;
    if (idx < 0) begin
      lat = 2; exp_err = 1'b1; exp_rd = '0;
    end else if (gw + rw <= TO - 1) begin
      lat = gw + rw + 2; exp_err = er; exp_rd = rd;
    end else begin
      lat = TO + 1; exp_err = 1'b1; exp_rd = '0; timed_out = 1'b1;
    end
    @(posedge clk); #1;
    mst_req[m] = 1'b0; mst_addr[m] = {$urandom, $urandom}; mst_wdata[m] = {$urandom, $urandom};
    mst_we[m] = ~we; mst_be[m] = ~be;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks_total++;
        if (idx < 0) begin
          if (slv_req !== 1'b0 || slv_sel !== '0)
            $display("FAIL derr_no_req addr %h: got req %b sel %b expected 0", addr, slv_req, slv_sel);
          else checks_passed++;
        end else begin
          if (slv_req !== 1'b1 || slv_sel !== (NS'(1) << idx) || slv_addr !== addr ||
              slv_we !== we || slv_wdata !== wd || slv_be !== be)
            $display("FAIL req_decode addr %h: got req %b sel %b addr %h we %b wd %h be %h expected sel %b",
                     addr, slv_req, slv_sel, slv_addr, slv_we, slv_wdata, slv_be, NS'(1) << idx);
          else checks_passed++;
        end
      end
      if (c < lat) begin
        checks_total++;
        if (mst_rvalid !== '0) $display("FAIL early_rvalid cycle %0d: got %b expected 0", c, mst_rvalid);
        else checks_passed++;
      end else begin
        checks_total++;
        if (mst_rvalid !== exp_hot || mst_err !== exp_err || mst_rdata !== exp_rd)
          $display("FAIL response addr %h lat %0d: got rv %b err %b rd %h expected rv %b err %b rd %h",
                   addr, lat, mst_rvalid, mst_err, mst_rdata, exp_hot, exp_err, exp_rd);
        else checks_passed++;
      end
    end
    if (timed_out) begin
      waited = 0;
      for (int c = 0; c < gw + rw + 2; c++) begin
        @(negedge clk);
        if (mst_rvalid !== '0 || slv_req !== 1'b0) waited++;
      end
      checks_total++;
      if (waited != 0) $display("FAIL late_rvalid_ignored: got %0d active cycles expected 0", waited);
      else checks_passed++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks_total++;
    if ({mst_gnt, mst_rvalid, mst_err, slv_req, slv_sel, slv_we} !== '0)
      $display("FAIL reset_ctrl: got gnt %b rv %b err %b req %b sel %b we %b expected 0",
               mst_gnt, mst_rvalid, mst_err, slv_req, slv_sel, slv_we);
    else checks_passed++;
    checks_total++;
    if ({mst_rdata, slv_addr, slv_wdata, slv_be} !== '0)
      $display("FAIL reset_data: got rd %h addr %h wd %h be %h expected 0", mst_rdata, slv_addr, slv_wdata, slv_be);
    else checks_passed++;
    @(negedge clk); rst_n = 1'b1;
    rr_model = 0;
  endtask

  task automatic test_uart_read();
    run_txn(0, 64'h1000_0000, 1'b0, 64'h0, 8'hFF, 0, 1, 64'hA5, 1'b0);
  endtask

  task automatic test_decode_error();
    run_txn(1, 64'h5000_0000, 1'b1, 64'h1234, 8'h0F, 0, 1, 64'hDEAD, 1'b0);
  endtask

  task automatic test_boundaries();
    run_txn(0, 64'hBFFF_FFFF, 1'b0, 64'h0, 8'hFF, 1, 1, 64'h11, 1'b0);
    run_txn(1, 64'hC000_0000, 1'b0, 64'h0, 8'hFF, 0, 1, 64'h22, 1'b0);
    run_txn(0, 64'h0,         1'b1, 64'h55, 8'h01, 0, 0, 64'h33, 1'b0);
    run_txn(1, 64'h0C3F_FFFE, 1'b0, 64'h0, 8'hFF, 2, 2, 64'h44, 1'b1);
  endtask

  task automatic test_back_to_back();
    int owner, grants, resps, cyc, idx;
    bit outstanding;
    logic [63:0] cur_addr [NM];
    logic [63:0] gaddr;
    gnt_wait = $urandom_range(0, 2); rv_wait = $urandom_range(1, 3);
    sl_rdata = {$urandom, $urandom}; sl_err = 1'b0;
    owner = 0; grants = 0; resps = 0; cyc = 0; outstanding = 1'b0; gaddr = '0;
    @(posedge clk); #1;
    for (int i = 0; i < NM; i++) begin
      cur_addr[i] = rand_addr(); mst_addr[i] = cur_addr[i]; mst_req[i] = 1'b1;
    end
    while (resps < 6 && cyc < 300) begin
      @(negedge clk); cyc++;
      if (mst_rvalid !== '0) begin
        idx = ref_decode(gaddr);
        checks_total++;
        if (!outstanding || mst_rvalid !== (NM'(1) << owner) ||
            mst_err !== (idx < 0) || mst_rdata !== ((idx < 0) ? 64'h0 : sl_rdata))
          $display("FAIL b2b_resp %0d: got rv %b err %b rd %h expected rv %b addr %h",
                   resps, mst_rvalid, mst_err, mst_rdata, NM'(1) << owner, gaddr);
        else checks_passed++;
        outstanding = 1'b0; resps++;
      end
      if (mst_gnt !== '0) begin
        checks_total++;
        if (outstanding || mst_gnt !== (NM'(1) << rr_model))
          $display("FAIL b2b_gnt %0d: got %b expected %b outstanding %0d", grants, mst_gnt, NM'(1) << rr_model, outstanding);
        else checks_passed++;
        owner = rr_model; gaddr = cur_addr[owner]; rr_model = (owner + 1) % NM;
        outstanding = 1'b1; grants++;
        @(posedge clk); #1;
        if (grants >= 6) mst_req = '0;
        else begin cur_addr[owner] = rand_addr(); mst_addr[owner] = cur_addr[owner]; end
      end
    end
    mst_req = '0;
    checks_total++;
    if (resps != 6) $display("FAIL b2b_progress: got %0d responses expected 6", resps);
    else checks_passed++;
  endtask

  task automatic test_timeout();
    run_txn(0, 64'h1000_0010, 1'b0, 64'h0, 8'hFF, 0, TO - 1, 64'h77, 1'b0);
    run_txn(1, 64'h4000_0000, 1'b0, 64'h0, 8'hFF, 0, TO + 4, 64'h88, 1'b0);
    run_txn(0, 64'h2000_0000, 1'b1, 64'h9, 8'h3C, TO + 1, 1, 64'h99, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++)
      run_txn($urandom_range(0, NM - 1), rand_addr(), 1'($urandom), {$urandom, $urandom},
              8'($urandom), $urandom_range(0, 3), $urandom_range(0, 5), {$urandom, $urandom}, 1'($urandom));
  endtask

  task automatic test_reset_mid_txn();
    int waited, active;
    bit got;
    gnt_wait = 0; rv_wait = 6; sl_rdata = 64'hF00D; sl_err = 1'b0;
    @(posedge clk); #1;
    mst_req[1] = 1'b1; mst_addr[1] = 64'h1000_0100;
    waited = 0; got = 1'b0;
    while (!got && waited < 20) begin
      @(negedge clk);
      if (mst_gnt !== '0) got = 1'b1; else waited++;
    end
    checks_total++;
    if (!got) $display("FAIL rst_mid_gnt: got %b expected %b", mst_gnt, 2'b10);
    else checks_passed++;
    @(posedge clk); #1; mst_req = '0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks_total++;
    if ({mst_gnt, mst_rvalid, mst_err, slv_req, slv_sel, slv_we, mst_rdata, slv_addr, slv_wdata, slv_be} !== '0)
      $display("FAIL rst_mid_outputs: got rv %b req %b sel %b addr %h expected all 0", mst_rvalid, slv_req, slv_sel, slv_addr);
    else checks_passed++;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; rr_model = 0;
    active = 0;
    repeat (8) begin @(negedge clk); if (mst_rvalid !== '0) active++; end
    checks_total++;
    if (active != 0) $display("FAIL rst_no_stale_resp: got %0d pulses expected 0", active);
    else checks_passed++;
    rv_wait = 1; sl_rdata = 64'hBEEF;
    @(posedge clk); #1;
    mst_req = '1; mst_addr[0] = 64'h1000_0200; mst_addr[1] = 64'h1000_0300;
    @(negedge clk);
    checks_total++;
    if (mst_gnt !== 2'b01) $display("FAIL rst_first_gnt: got %b expected 01", mst_gnt);
    else checks_passed++;
    rr_model = 1;
    @(posedge clk); #1; mst_req = '0;
    repeat (3) @(negedge clk);
    checks_total++;
    if (mst_rvalid !== 2'b01 || mst_rdata !== 64'hBEEF || mst_err !== 1'b0)
      $display("FAIL rst_after_resp: got rv %b rd %h err %b expected 01 beef 0", mst_rvalid, mst_rdata, mst_err);
    else checks_passed++;
  endtask

  initial begin
    test_reset();
    test_uart_read();
    test_decode_error();
    test_boundaries();
    test_back_to_back();
    test_timeout();
    test_random();
    test_reset_mid_txn();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
